// File: rtl/life_ctrl.sv
// Life board sequencer: keypad release decoding, edit cursor, grid write handshake,
// and scheduling of single-step or free-running generation starts.
module life_ctrl #(
  parameter int              X          = 8,
  parameter int              Y          = 8,
  parameter int              LOG2X      = 3,
  parameter int              LOG2Y      = 3,
  parameter int              CNT_W      = 24,
  parameter logic [CNT_W-1:0] GEN_PERIOD = CNT_W'(5000000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       keys,
  input  logic             cell_val,
  output logic             wr_req,
  output logic [LOG2X-1:0] wr_x,
  output logic [LOG2Y-1:0] wr_y,
  output logic             wr_data,
  input  logic             wr_ack,
  output logic             gen_start,
  input  logic             gen_busy,
  output logic [LOG2X-1:0] cursor_x,
  output logic [LOG2Y-1:0] cursor_y,
  output logic             running
);

  localparam logic [2:0] KEY_NONE   = 3'd0;
  localparam logic [2:0] KEY_UP     = 3'd1;
  localparam logic [2:0] KEY_DOWN   = 3'd2;
  localparam logic [2:0] KEY_LEFT   = 3'd3;
  localparam logic [2:0] KEY_RIGHT  = 3'd4;
  localparam logic [2:0] KEY_SELECT = 3'd5;
  localparam logic [2:0] KEY_RUN    = 3'd6;
  localparam logic [2:0] KEY_STEP   = 3'd7;

  localparam logic [LOG2X-1:0] X_MAX    = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] Y_MAX    = LOG2Y'(Y - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = GEN_PERIOD - 1'b1;

  typedef enum logic [1:0] {S_EDIT, S_WR, S_RUN, S_GEN} state_t;

  state_t             state, state_n;
  logic [2:0]         k_d;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               seen_busy, seen_busy_n;
  logic               stop_pend, stop_pend_n;
  logic               ret_run, ret_run_n;
  logic               wr_req_n, wr_data_n, gen_start_n, running_n;
  logic [LOG2X-1:0]   wr_x_n, cursor_x_n;
  logic [LOG2Y-1:0]   wr_y_n, cursor_y_n;

  // A key event fires only on the cycle its code disappears from the keypad.
  logic ev_up, ev_down, ev_left, ev_right, ev_select, ev_run, ev_step;
  assign ev_up     = (k_d == KEY_UP)     && (keys != KEY_UP);
  assign ev_down   = (k_d == KEY_DOWN)   && (keys != KEY_DOWN);
  assign ev_left   = (k_d == KEY_LEFT)   && (keys != KEY_LEFT);
  assign ev_right  = (k_d == KEY_RIGHT)  && (keys != KEY_RIGHT);
  assign ev_select = (k_d == KEY_SELECT) && (keys != KEY_SELECT);
  assign ev_run    = (k_d == KEY_RUN)    && (keys != KEY_RUN);
  assign ev_step   = (k_d == KEY_STEP)   && (keys != KEY_STEP);

  // NOTE: every state element uses <= so all registers see pre-edge values together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_EDIT;
      k_d       <= KEY_NONE;
      cnt       <= '0;
      seen_busy <= 1'b0;
      stop_pend <= 1'b0;
      ret_run   <= 1'b0;
      wr_req    <= 1'b0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_data   <= 1'b0;
      gen_start <= 1'b0;
      running   <= 1'b0;
      cursor_x  <= '0;
      cursor_y  <= '0;
    end else begin
      state     <= state_n;
      k_d       <= keys;
      cnt       <= cnt_n;
      seen_busy <= seen_busy_n;
      stop_pend <= stop_pend_n;
      ret_run   <= ret_run_n;
      wr_req    <= wr_req_n;
      wr_x      <= wr_x_n;
      wr_y      <= wr_y_n;
      wr_data   <= wr_data_n;
      gen_start <= gen_start_n;
      running   <= running_n;
      cursor_x  <= cursor_x_n;
      cursor_y  <= cursor_y_n;
    end
  end

  // NOTE: every signal gets a hold/default value first so no path infers a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    seen_busy_n = seen_busy;
    stop_pend_n = stop_pend;
    ret_run_n   = ret_run;
    wr_req_n    = wr_req;
    wr_x_n      = wr_x;
    wr_y_n      = wr_y;
    wr_data_n   = wr_data;
    gen_start_n = 1'b0;
    running_n   = running;
    cursor_x_n  = cursor_x;
    cursor_y_n  = cursor_y;

    case (state)
      S_EDIT: begin
        if (ev_down)       cursor_y_n = (cursor_y == Y_MAX) ? '0 : cursor_y + LOG2Y'(1);
        else if (ev_up)    cursor_y_n = (cursor_y == '0) ? Y_MAX : cursor_y - LOG2Y'(1);
        if (ev_left)       cursor_x_n = (cursor_x == X_MAX) ? '0 : cursor_x + LOG2X'(1);
        else if (ev_right) cursor_x_n = (cursor_x == '0) ? X_MAX : cursor_x - LOG2X'(1);

        // The write targets the cursor as it was before any coincident move.
        if (ev_select) begin
          wr_x_n    = cursor_x;
          wr_y_n    = cursor_y;
          wr_data_n = ~cell_val;
          wr_req_n  = 1'b1;
          state_n   = S_WR;
        end else if (ev_run) begin
          running_n = 1'b1;
          cnt_n     = '0;
          state_n   = S_RUN;
        end else if (ev_step) begin
          gen_start_n = 1'b1;
          ret_run_n   = 1'b0;
          seen_busy_n = 1'b0;
          stop_pend_n = 1'b0;
          state_n     = S_GEN;
        end
      end

      S_WR: begin
        if (wr_ack) begin
          wr_req_n = 1'b0;
          state_n  = S_EDIT;
        end
      end

      S_RUN: begin
        if (ev_run) begin
          running_n = 1'b0;
          state_n   = S_EDIT;
        end else if (cnt == CNT_LAST) begin
          cnt_n       = '0;
          gen_start_n = 1'b1;
          ret_run_n   = 1'b1;
          seen_busy_n = 1'b0;
          stop_pend_n = 1'b0;
          state_n     = S_GEN;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_GEN: begin
        seen_busy_n = seen_busy | gen_busy;
        stop_pend_n = stop_pend | ev_run;
        // A stop request arriving on the exit cycle itself is honoured too.
        if (seen_busy && !gen_busy) begin
          cnt_n       = '0;
          seen_busy_n = 1'b0;
          stop_pend_n = 1'b0;
          if (stop_pend || ev_run || !ret_run) begin
            running_n = 1'b0;
            state_n   = S_EDIT;
          end else begin
            state_n = S_RUN;
          end
        end
      end

      default: state_n = S_EDIT;
    endcase
  end

endmodule

// File: tb/tb_life_ctrl.sv
// Bench for life_ctrl: directed scenarios with literal expectations, then random keypad,
// ack and busy traffic, all checked every cycle against an abstract reference model.
module tb_life_ctrl;

  localparam int NX = 8;
  localparam int NY = 8;
  localparam int GP = 4;

  localparam logic [2:0] K_NONE   = 3'd0;
  localparam logic [2:0] K_UP     = 3'd1;
  localparam logic [2:0] K_DOWN   = 3'd2;
  localparam logic [2:0] K_LEFT   = 3'd3;
  localparam logic [2:0] K_RIGHT  = 3'd4;
  localparam logic [2:0] K_SELECT = 3'd5;
  localparam logic [2:0] K_RUN    = 3'd6;
  localparam logic [2:0] K_STEP   = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] keys;
  logic       cell_val;
  logic       wr_req;
  logic [2:0] wr_x;
  logic [2:0] wr_y;
  logic       wr_data;
  logic       wr_ack;
  logic       gen_start;
  logic       gen_busy;
  logic [2:0] cursor_x;
  logic [2:0] cursor_y;
  logic       running;

  life_ctrl #(
    .X(NX), .Y(NY), .LOG2X(3), .LOG2Y(3), .CNT_W(24), .GEN_PERIOD(24'd4)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys), .cell_val(cell_val),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
    .gen_start(gen_start), .gen_busy(gen_busy),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .running(running)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: board mode, cursor modulo arithmetic, pending write, generation bookkeeping.
  typedef enum int {MD_EDIT, MD_WRITE, MD_RUN, MD_GEN} mode_t;
  mode_t      m_mode;
  int         m_x, m_y, m_wx, m_wy, m_run_cycles;
  logic       m_wreq, m_wd, m_gs, m_running, m_from_run, m_busy_seen, m_stop;
  logic [2:0] m_prev_key;
  logic       grid [NY][NX];

  int busy_cnt, eng_delay, eng_len;

  task automatic model_reset();
    m_mode = MD_EDIT;
    m_x = 0; m_y = 0; m_wx = 0; m_wy = 0; m_run_cycles = 0;
    m_wreq = 0; m_wd = 0; m_gs = 0; m_running = 0;
    m_from_run = 0; m_busy_seen = 0; m_stop = 0;
    m_prev_key = K_NONE;
    busy_cnt = 0; eng_delay = 0; eng_len = 0;
  endtask

  task automatic model_update();
    logic [2:0] rel;
    if (!reset) begin
      model_reset();
    end else begin
      rel = (m_prev_key != K_NONE && keys != m_prev_key) ? m_prev_key : K_NONE;
      m_prev_key = keys;
      m_gs = 1'b0;
      case (m_mode)
        MD_EDIT: begin
          if (rel == K_DOWN)  m_y = (m_y + 1) % NY;
          if (rel == K_UP)    m_y = (m_y + NY - 1) % NY;
          if (rel == K_LEFT)  m_x = (m_x + 1) % NX;
          if (rel == K_RIGHT) m_x = (m_x + NX - 1) % NX;
          if (rel == K_SELECT) begin
            m_wx = m_x; m_wy = m_y; m_wd = !cell_val; m_wreq = 1; m_mode = MD_WRITE;
          end else if (rel == K_RUN) begin
            m_running = 1; m_run_cycles = 0; m_mode = MD_RUN;
          end else if (rel == K_STEP) begin
            m_gs = 1; m_from_run = 0; m_busy_seen = 0; m_stop = 0; m_mode = MD_GEN;
          end
        end
        MD_WRITE: begin
          if (wr_ack) begin
            grid[3'(m_wy)][3'(m_wx)] = m_wd;
            m_wreq = 0;
            m_mode = MD_EDIT;
          end
        end
        MD_RUN: begin
          if (rel == K_RUN) begin
            m_running = 0; m_mode = MD_EDIT;
          end else begin
            m_run_cycles++;
            if (m_run_cycles == GP) begin
              m_gs = 1; m_from_run = 1; m_busy_seen = 0; m_stop = 0; m_mode = MD_GEN;
            end
          end
        end
        MD_GEN: begin
          if (m_busy_seen && !gen_busy) begin
            if (m_stop || rel == K_RUN || !m_from_run) begin
              m_running = 0; m_mode = MD_EDIT;
            end else begin
              m_run_cycles = 0; m_mode = MD_RUN;
            end
          end else begin
            if (gen_busy) m_busy_seen = 1;
            if (rel == K_RUN) m_stop = 1;
          end
        end
        default: m_mode = MD_EDIT;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    cell_val = grid[3'(m_y)][3'(m_x)];
  endtask

  task automatic press(input logic [2:0] k);
    keys = k;
    tick();
    keys = K_NONE;
    tick();
  endtask

  // Engine with a fixed 3-cycle busy window right after each start pulse.
  task automatic engine3();
    if (m_gs) begin
      busy_cnt = 3; gen_busy = 0;
    end else if (busy_cnt > 0) begin
      gen_busy = 1; busy_cnt--;
    end else begin
      gen_busy = 0;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cursor_x",  32'(cursor_x),  32'(m_x));
      check("cursor_y",  32'(cursor_y),  32'(m_y));
      check("wr_req",    32'(wr_req),    32'(m_wreq));
      check("wr_x",      32'(wr_x),      32'(m_wx));
      check("wr_y",      32'(wr_y),      32'(m_wy));
      check("wr_data",   32'(wr_data),   32'(m_wd));
      check("gen_start", 32'(gen_start), 32'(m_gs));
      check("running",   32'(running),   32'(m_running));
    end
  end

  int exp_y [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
  int pulse_at [8];
  int npulse, pulses, stops, hold, r;

  initial begin
    for (int yy = 0; yy < NY; yy++)
      for (int xx = 0; xx < NX; xx++)
        grid[yy][xx] = 1'b0;
    model_reset();
    reset = 0; keys = K_NONE; cell_val = 0; wr_ack = 0; gen_busy = 0;
    tick();
    tick();
    cmp_en = 1'b1;
    check("rst_cursor_x",  32'(cursor_x),  0);
    check("rst_cursor_y",  32'(cursor_y),  0);
    check("rst_wr_req",    32'(wr_req),    0);
    check("rst_gen_start", 32'(gen_start), 0);
    check("rst_running",   32'(running),   0);
    reset = 1;
    tick();

    // Y wrap via nine DOWN releases.
    for (int i = 0; i < 9; i++) begin
      press(K_DOWN);
      check("down_y", 32'(cursor_y), 32'(exp_y[i]));
      check("down_x", 32'(cursor_x), 0);
    end

    // X wrap in both directions.
    press(K_RIGHT);
    check("right_wrap", 32'(cursor_x), 7);
    press(K_LEFT);
    check("left_wrap", 32'(cursor_x), 0);

    // Move to row 2, column 3 and toggle with a slow ack.
    press(K_DOWN);
    repeat (3) press(K_LEFT);
    check("sel_pos_y", 32'(cursor_y), 2);
    check("sel_pos_x", 32'(cursor_x), 3);
    press(K_SELECT);
    for (int i = 1; i <= 5; i++) begin
      check("wr_hold_req",  32'(wr_req),  1);
      check("wr_hold_x",    32'(wr_x),    3);
      check("wr_hold_y",    32'(wr_y),    2);
      check("wr_hold_data", 32'(wr_data), 1);
      keys   = (i == 1) ? K_DOWN : K_NONE;
      wr_ack = (i == 5);
      tick();
    end
    wr_ack = 0;
    check("wr_done_req", 32'(wr_req), 0);
    check("wr_drop_key", 32'(cursor_y), 2);

    // Single step: busy on cycles 2..10 after the pulse; UP released while still in
    // generation is dropped, DOWN released on the first edit cycle moves the cursor.
    press(K_STEP);
    pulses = 0;
    for (int i = 1; i <= 14; i++) begin
      if (gen_start) pulses++;
      gen_busy = (i >= 2 && i <= 10);
      keys = (i == 10) ? K_UP : (i == 11) ? K_DOWN : K_NONE;
      check("step_running", 32'(running), 0);
      tick();
    end
    gen_busy = 0;
    check("step_pulses", 32'(pulses), 1);
    check("step_exit_y", 32'(cursor_y), 3);

    // Free run: 4 run cycles + 5 generation cycles (pulse, 3 busy, falling cycle) = 9.
    press(K_RUN);
    check("run_on", 32'(running), 1);
    busy_cnt = 0;
    npulse = 0;
    for (int i = 1; i <= 40; i++) begin
      if (gen_start && npulse < 8) begin
        pulse_at[npulse] = i;
        npulse++;
      end
      check("run_running", 32'(running), 1);
      engine3();
      tick();
    end
    check("run_npulse", 32'(npulse), 4);
    check("run_first", 32'(pulse_at[0]), 5);
    for (int k = 1; k < npulse; k++)
      check("run_interval", 32'(pulse_at[k] - pulse_at[k-1]), 9);

    // Stop requested during a generation: no more pulses, edit mode afterwards.
    stops = 0;
    for (int j = 1; j <= 30; j++) begin
      if (j >= 2 && gen_start) stops++;
      if (j == 6) check("stop_running", 32'(running), 0);
      engine3();
      keys = (j == 1) ? K_RUN : K_NONE;
      tick();
    end
    gen_busy = 0;
    check("stop_no_pulse", 32'(stops), 0);
    press(K_DOWN);
    check("stop_edit_y", 32'(cursor_y), 4);

    // Asynchronous reset in the middle of a write.
    press(K_SELECT);
    check("mid_wr_req", 32'(wr_req), 1);
    check("mid_wr_data", 32'(wr_data), 1);
    #2;
    reset = 0;
    model_reset();
    #1;
    check("async_wr_req", 32'(wr_req), 0);
    check("async_cursor_y", 32'(cursor_y), 0);
    tick();
    tick();
    reset = 1;
    tick();

    // Asynchronous reset in the middle of a free-run generation.
    press(K_RUN);
    repeat (4) tick();
    check("gen_pulse", 32'(gen_start), 1);
    tick();
    #2;
    reset = 0;
    model_reset();
    #1;
    check("async_running", 32'(running), 0);
    check("async_gen_start", 32'(gen_start), 0);
    tick();
    reset = 1;
    tick();

    // Random traffic against the model.
    hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        r = int'($urandom_range(0, 9));
        keys = (r < 3) ? K_NONE : 3'(r - 2);
        hold = int'($urandom_range(1, 3));
      end
      hold--;
      wr_ack = m_wreq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      if (m_gs) begin
        eng_delay = int'($urandom_range(0, 2));
        eng_len   = int'($urandom_range(1, 4));
        gen_busy  = 0;
      end else if (eng_delay > 0) begin
        eng_delay--;
        gen_busy = 0;
      end else if (eng_len > 0) begin
        eng_len--;
        gen_busy = 1;
      end else begin
        gen_busy = 0;
      end
      tick();
    end
    keys = K_NONE; wr_ack = 0; gen_busy = 0;
    tick();
    tick();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
